seq_mult16: RTL and testbench



---
 rtl/apu_pkg.sv | 13 +
 rtl/seq_mult16_and.sv | 10 +
 rtl/seq_mult16.sv | 103 ++++++++++
 tb/tb_seq_mult16.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/apu_pkg.sv
// Shared APU datapath constants and the sequencer state encoding.
package apu_pkg;

  localparam int unsigned APU_WIDTH  = 16;
  localparam int unsigned MULT_ITERS = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mult_state_e;

endpackage

// File: rtl/seq_mult16_and.sv
// MultiAnd16: 16-bit bus-AND gate forming one shift-add partial product.
module MultiAnd16 (
  input  logic [15:0] a,
  input  logic        b,
  output logic [15:0] y
);

  assign y = a & {16{b}};

endmodule

// File: rtl/seq_mult16.sv
// Sequential 16x16 unsigned shift-add multiplier with start/busy/done handshake.
// Optional macro SEQ_MULT_ZERO_SKIP_EN: zero operands complete without iterating.
module seq_mult16
  import apu_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  generate
    if (WIDTH != APU_WIDTH) begin : g_bad_width
      $error("seq_mult16: only WIDTH == 16 is supported");
    end
    if ((64'd1 << CNT_W) <= 64'(WIDTH)) begin : g_bad_cnt_w
      $error("seq_mult16: CNT_W too narrow to count WIDTH iterations");
    end
  endgenerate

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(MULT_ITERS - 1);

  mult_state_e        state_q, state_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   pp;
  logic [WIDTH:0]     sum;

  MultiAnd16 u_pp (
    .a (m_q),
    .b (p_q[0]),
    .y (pp)
  );

  assign sum = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, pp};

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        p_d   = {sum, p_q[WIDTH-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ITER) state_d = DONE;
      end
      default: begin
        if (start) begin
          m_d     = a;
          p_d     = {{WIDTH{1'b0}}, b};
          cnt_d   = '0;
          state_d = RUN;
`ifdef SEQ_MULT_ZERO_SKIP_EN
          if (a == '0 || b == '0) begin
            p_d     = '0;
            state_d = DONE;
          end
`endif
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
    endcase
    // Outputs are registered from the next state so they align with it.
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      m_q     <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = p_q;

endmodule

// File: tb/tb_seq_mult16.sv
// Directed self-checking bench for seq_mult16 (honours SEQ_MULT_ZERO_SKIP_EN).
module tb_seq_mult16;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] a_i;
  logic [15:0] b_i;
  logic        busy;
  logic        done;
  logic [31:0] product;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  seq_mult16 #(.WIDTH(16), .CNT_W(5)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .a       (a_i),
    .b       (b_i),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands with start for one accepting edge, then scramble them.
  task automatic issue(input logic [15:0] a, input logic [15:0] b);
    start = 1'b1;
    a_i   = a;
    b_i   = b;
    tick();
    start = 1'b0;
    a_i   = 16'hDEAD;
    b_i   = 16'hBEEF;
  endtask

  // Called just after the accepting edge; stops in the done cycle.
  task automatic wait_done(input string tag, input logic [31:0] exp_prod,
                           input int unsigned exp_lat, input int unsigned exp_busy,
                           input int glitch_at);
    int unsigned cycles   = 0;
    int unsigned busy_cnt = 0;
    while (!done && cycles < 40) begin
      if (busy) busy_cnt++;
      if (int'(cycles) == glitch_at) begin
        start = 1'b1;
        a_i   = 16'h1234;
        b_i   = 16'h1111;
      end else begin
        start = 1'b0;
      end
      tick();
      cycles++;
    end
    start = 1'b0;
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_latency"}, cycles + 1, exp_lat);
    check({tag, "_busy_cycles"}, busy_cnt, exp_busy);
    check({tag, "_product"}, product, exp_prod);
  endtask

  task automatic check_after_done(input string tag, input logic [31:0] exp_prod);
    tick();
    check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    check({tag, "_busy_idle"}, {31'd0, busy}, 32'd0);
    check({tag, "_held"}, product, exp_prod);
  endtask

  initial begin
    int unsigned done_seen;
    int unsigned skip_lat;
    int unsigned skip_busy;
    reset = 1'b1;
    start = 1'b0;
    a_i   = '0;
    b_i   = '0;

    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_product", product, 32'h0000_0000);

    issue(16'h0003, 16'h0005);
    wait_done("mul_3x5", 32'h0000_000F, 17, 16, -1);
    check_after_done("mul_3x5", 32'h0000_000F);
    repeat (3) tick();
    check("mul_3x5_hold_idle", product, 32'h0000_000F);

    issue(16'hFFFF, 16'hFFFF);
    wait_done("mul_max", 32'hFFFE_0001, 17, 16, -1);
    check_after_done("mul_max", 32'hFFFE_0001);

    issue(16'h8000, 16'h0002);
    wait_done("mul_msb", 32'h0001_0000, 17, 16, -1);
    check_after_done("mul_msb", 32'h0001_0000);

    // Start pulsed mid-run must be ignored; then back-to-back from DONE.
    issue(16'h0007, 16'h0009);
    wait_done("mul_glitch", 32'h0000_003F, 17, 16, 5);
    issue(16'h0010, 16'h0010);
    wait_done("mul_b2b", 32'h0000_0100, 17, 16, -1);
    check_after_done("mul_b2b", 32'h0000_0100);

    // Reset during iteration 8 discards the in-flight result.
    issue(16'h00FF, 16'h0101);
    repeat (7) tick();
    check("midrst_busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_product", product, 32'h0000_0000);
    done_seen = 0;
    repeat (25) begin
      tick();
      if (done) done_seen++;
    end
    check("midrst_no_done", done_seen, 0);
    check("midrst_product_after", product, 32'h0000_0000);

`ifdef SEQ_MULT_ZERO_SKIP_EN
    skip_lat  = 1;
    skip_busy = 0;
`else
    skip_lat  = 17;
    skip_busy = 16;
`endif
    issue(16'h0000, 16'hABCD);
    wait_done("mul_zero", 32'h0000_0000, skip_lat, skip_busy, -1);
    check_after_done("mul_zero", 32'h0000_0000);

    issue(16'h0002, 16'h0003);
    wait_done("mul_after_zero", 32'h0000_0006, 17, 16, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
